// File: rtl/rv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv_fetch_pkg
// Shared configuration for the instruction-fetch front end.
//   XLEN / IMEM_A_BIT        : datapath width and instruction-memory byte
//                              address width.
//   RESET_PC_DEFAULT         : default fetch PC loaded by reset.
//   FQ_DEPTH_DEFAULT         : default fetch-queue depth (power of two, >= 2).
//   fq_entry_t               : one fetch-queue entry, {pc, inst}.
//   align_pc()               : forces a PC onto a 4-byte boundary.
// ---------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int IMEM_A_BIT = 10;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int              FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    localparam int FQ_ENTRY_W = $bits(fq_entry_t);

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~(XLEN'(3));

    // Instructions are word aligned; the two low bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/rv_fetch_queue.sv
// ---------------------------------------------------------------------------
// rv_fetch_queue
// Generic synchronous FIFO used as the fetch queue.
//   clk, rst   : clock, asynchronous active-high reset (control state only;
//                the storage array is not reset).
//   push, din  : write din at the tail. Accepted when not full, or when full
//                and a pop happens in the same cycle.
//   pop, dout  : dout is the head entry; pop removes it (ignored when empty).
//   flush      : empties the queue; overrides push and pop.
//   count      : number of stored entries (0..DEPTH).
//   full/empty : count == DEPTH / count == 0.
// ---------------------------------------------------------------------------
module rv_fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int DATA_W = FQ_ENTRY_W,
    parameter int DEPTH  = FQ_DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A full queue can still take a write when the head leaves this cycle.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rv_fetch.sv
// ---------------------------------------------------------------------------
// rv_fetch
// Instruction-fetch front end (requester side of the instruction memory).
//   i_clk, i_rst        : clock, asynchronous active-high reset.
//   o_imem_ra           : word address into the combinational-read memory,
//                         f_pc[IMEM_A_BIT-1:2].
//   i_imem_rd           : instruction word returned in the same cycle.
//   i_redirect(_pc)     : flush the queue and restart fetch at the target.
//   o_inst_valid        : queue head valid.
//   i_inst_ready        : decode takes the head this cycle.
//   o_inst, o_inst_pc   : head instruction and its PC (zero while empty).
// ---------------------------------------------------------------------------
module rv_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [IMEM_A_BIT-3:0] o_imem_ra,
    input  logic [XLEN-1:0]       i_imem_rd,
    input  logic                  i_redirect,
    input  logic [XLEN-1:0]       i_redirect_pc,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [XLEN-1:0]       o_inst,
    output logic [XLEN-1:0]       o_inst_pc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] f_pc;
    logic            pop;
    logic            push;
    fq_entry_t       wr_entry;
    fq_entry_t       rd_entry;
    logic [CW-1:0]   fq_count;
    logic            fq_full;
    logic            fq_empty;

    assign o_imem_ra    = f_pc[IMEM_A_BIT-1:2];
    assign o_inst_valid = (fq_count != '0);
    assign pop          = o_inst_valid & i_inst_ready;
    // Redirect suppresses the push so the stale fall-through word is dropped.
    assign push         = ~i_redirect & (~fq_full | pop);
    assign wr_entry     = '{pc: f_pc, inst: i_imem_rd};

    // Storage is not reset, so the head is masked to zero while empty.
    assign o_inst    = fq_empty ? '0 : rd_entry.inst;
    assign o_inst_pc = fq_empty ? '0 : rd_entry.pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_pc <= RESET_PC;
        end else if (i_redirect) begin
            f_pc <= align_pc(i_redirect_pc);
        end else if (push) begin
            f_pc <= f_pc + XLEN'(4);
        end
    end

    rv_fetch_queue #(
        .DATA_W (FQ_ENTRY_W),
        .DEPTH  (FQ_DEPTH)
    ) u_fq (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect),
        .din   (wr_entry),
        .dout  (rd_entry),
        .count (fq_count),
        .full  (fq_full),
        .empty (fq_empty)
    );

endmodule

// File: tb/tb_rv_fetch.sv
// ---------------------------------------------------------------------------
// tb_rv_fetch
// Directed bench for rv_fetch. The instruction memory returns 32'h13 + word
// index. Expected PCs are queued when a fetch stream is started (reset or
// redirect) and popped/compared on every decode handshake.
// ---------------------------------------------------------------------------
module tb_rv_fetch;
    import rv_fetch_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [IMEM_A_BIT-3:0] imem_ra;
    logic [XLEN-1:0]       imem_rd;
    logic                  redirect;
    logic [XLEN-1:0]       redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [XLEN-1:0]       inst;
    logic [XLEN-1:0]       inst_pc;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q [$];

    rv_fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_ra     (imem_ra),
        .i_imem_rd     (imem_rd),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_inst_valid  (inst_valid),
        .i_inst_ready  (inst_ready),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word k holds 32'h13 + k.
    assign imem_rd = 32'h13 + 32'(imem_ra);

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] pc);
        logic [IMEM_A_BIT-3:0] w;
        w = pc[IMEM_A_BIT-1:2];
        return 32'h13 + 32'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a new expected stream at pc (wraps modulo 2^32).
    task automatic load(input logic [XLEN-1:0] pc);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(pc + XLEN'(4 * k));
    endtask

    // Run one clock with the current inputs. Called at a falling edge; any
    // handshake that the coming rising edge will take is scored first.
    task automatic tick();
        logic [XLEN-1:0] e;
        if (inst_valid && inst_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed_pc=%h expected=none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e);
                chk("sb_inst", inst, mem_word(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_ra", 32'(imem_ra), 32'd0);

        // Free run from reset
        load(32'h0);
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("c1_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        tick();
        chk("c2_valid", 32'(inst_valid), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("run_valid", 32'(inst_valid), 32'd1);
            tick();
        end

        // Async reset between edges
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_pc", inst_pc, 32'd0);
        @(negedge clk);
        chk("arst_ra", 32'(imem_ra), 32'd0);

        // Backpressure: refetch from RESET_PC with decode stalled
        load(32'h0);
        inst_ready = 1'b0;
        rst        = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_ra", 32'(imem_ra), 32'd4);
        chk("bp_count", 32'(dut.u_fq.count), 32'd4);
        tick();
        chk("bp_ra_hold", 32'(imem_ra), 32'd4);
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("drain_valid", 32'(inst_valid), 32'd1);
            tick();
        end
        chk("drain_count", 32'(dut.u_fq.count), 32'd4);

        // Redirect mid-stream
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        load(32'h40);
        redirect = 1'b0;
        chk("redir_n1_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("redir_n2_valid", 32'(inst_valid), 32'd1);
        chk("redir_n2_pc", inst_pc, 32'h40);
        for (int k = 0; k < 3; k++) tick();

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h46;
        tick();
        load(32'h44);
        redirect = 1'b0;
        chk("mis_n1_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("mis_n2_pc", inst_pc, 32'h44);
        for (int k = 0; k < 2; k++) tick();

        // Full with push/pop, then redirect in the same cycle
        inst_ready = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("full_count", 32'(dut.u_fq.count), 32'd4);
        inst_ready = 1'b1;
        tick();
        chk("full_pp_count", 32'(dut.u_fq.count), 32'd4);
        tick();
        chk("full_pp_count2", 32'(dut.u_fq.count), 32'd4);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        load(32'h100);
        redirect = 1'b0;
        chk("full_redir_count", 32'(dut.u_fq.count), 32'd0);
        chk("full_redir_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("full_redir_pc", inst_pc, 32'h100);
        for (int k = 0; k < 2; k++) tick();

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        load(32'hFFFF_FFFC);
        redirect = 1'b0;
        chk("wrap_ra_target", 32'(imem_ra), 32'hFF);
        tick();
        chk("wrap_ra_next", 32'(imem_ra), 32'd0);
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        for (int k = 0; k < 3; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
- Instruction-fetch front end. It is the requester side of the instruction-memory read interface.
- Holds the fetch PC and drives the word address to the combinational-read instruction memory.
- Captures the returned instruction, together with its PC, into a small queue.
- Presents instructions to decode through a valid/ready handshake, and flushes and refetches on a redirect from the execute stage (branch, jump or trap).

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded by reset. Bits [1:0] must be 0.
- FQ_DEPTH, 4, fetch-queue entries. Must be a power of two, at least 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- o_imem_ra  output  IMEM_A_BIT-2  instruction-memory word address, equal to f_pc[IMEM_A_BIT-1:2].
- i_imem_rd  input  XLEN  instruction word returned combinationally in the same cycle as o_imem_ra.
- i_redirect  input  1  flush the queue and restart fetch at i_redirect_pc.
- i_redirect_pc  input  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- o_inst_valid  output  1  queue head is valid.
- i_inst_ready  input  1  decode accepts the head this cycle.
- o_inst  output  XLEN  instruction at the queue head.
- o_inst_pc  output  XLEN  PC of the instruction at the queue head.

Behaviour:
- Clock and reset: one clock domain, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values:
  - f_pc = RESET_PC.
  - Queue count = 0; read and write pointers = 0.
  - o_inst_valid = 0.
  - o_inst and o_inst_pc = 0; the queue storage itself is not reset.
  - Reset asserted mid-operation discards all queued entries immediately.
- Address output: o_imem_ra = f_pc[IMEM_A_BIT-1:2] every cycle, as pure combinational logic from the f_pc register.
- Pop: pop = o_inst_valid & i_inst_ready.
- Push: push = ~i_redirect & (count < FQ_DEPTH | pop).
  - A push writes {f_pc, i_imem_rd} at the tail and sets f_pc <= f_pc + 4.
  - The PC adder is XLEN wide and wraps modulo 2^32.
  - The memory address wraps naturally through truncation to IMEM_A_BIT-2 bits.
- Full: with no pop, no push occurs, f_pc holds and o_imem_ra is stable. Pushing and popping in the same cycle while full is legal; count is unchanged.
- Empty: o_inst_valid = 0, and i_inst_ready is ignored.
- Head outputs: o_inst_valid = (count != 0). o_inst and o_inst_pc come from the head entry, read from registered storage with no combinational path from i_imem_rd.
- Redirect (cycle N):
  - Priority over every other event.
  - At the edge: count, read pointer and write pointer are cleared, and f_pc <= {i_redirect_pc[XLEN-1:2], 2'b00}.
  - No push occurs in cycle N.
  - A pop handshaked in cycle N counts as consumed by decode, which is responsible for squashing it.
  - Cycle N+1: o_inst_valid = 0, and the target is pushed.
  - Cycle N+2: o_inst_valid = 1 with o_inst_pc = target, giving a 2-cycle redirect penalty.
  - Back-to-back redirects: the last one wins.
- Reset latency: the first push occurs in the first cycle after i_rst deasserts, and o_inst_valid rises one cycle later.
- Throughput: 1 instruction per cycle in steady state while i_inst_ready = 1.
- Counter widths: count is $clog2(FQ_DEPTH)+1 bits. The pointers are $clog2(FQ_DEPTH) bits and wrap modulo FQ_DEPTH.

Decomposition:
- Shared configuration header rv_configs.v:
  - XLEN and IMEM_A_BIT (existing).
  - New: RESET_PC_DEFAULT and FQ_DEPTH_DEFAULT, used as the parameter defaults.
- Sub-module rv_fetch_queue: a generic synchronous FIFO.
  - Parameters: width and depth.
  - Ports: push/pop, flush, data in/out, count, full/empty.
  - Uses the same clock and asynchronous active-high reset.
- The rv_fetch top holds only the PC, the push/redirect control and the address mapping.

Test Plan:
- Reset then free run: memory words 0..7 hold 32'h00000013 + k. With i_inst_ready = 1, o_inst_valid rises in cycle 2 after deassert, and the bench sees PCs 0, 4, 8, … with o_inst = 13, 14, 15, … on consecutive cycles.
- Backpressure: i_inst_ready = 0 for 10 cycles, so the queue fills to 4. f_pc holds at 16 and o_imem_ra holds at 4. On release, PCs 0, 4, 8, 12, 16 follow with no gap or duplicate.
- Redirect: assert i_redirect with i_redirect_pc = 32'h40 mid-stream. Next cycle o_inst_valid = 0; the cycle after, o_inst_pc = 32'h40, and no stale entries appear.
- Misaligned redirect: i_redirect_pc = 32'h46 gives o_inst_pc = 32'h44.
- Full push/pop plus redirect: with the queue full and i_inst_ready = 1, count stays at 4. Asserting i_redirect in the same cycle flushes to 0 and takes priority.
- Async reset mid-stream: pulse i_rst between clock edges. o_inst_valid drops immediately without waiting for a clock edge, and after release fetch restarts at RESET_PC.
- Wrap: i_redirect_pc = 32'hFFFF_FFFC gives the next PC 32'h0000_0000 and o_imem_ra = 0.
